// File: rtl/pwm_pkg.sv
// pwm_pkg: register indices, CTRL field positions and counter widths shared by the PWM LED block
package pwm_pkg;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DUTY_LO = 2'd2;
  localparam logic [1:0] REG_DUTY_HI = 2'd3;
  localparam int EN_BIT    = 0;
  localparam int PRESC_LSB = 16;
  localparam int CNT_W     = 8;
  localparam int PRESC_W   = 16;
endpackage

// File: rtl/iomem_pwm_leds_if.sv
// iomem_pwm_leds_if: picosoc iomem bus (valid/ready handshake, wstrb, addr, wdata, rdata) with master/slave views
interface iomem_pwm_leds_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
  modport slave  (input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel; ports clk, reset, en, cnt, load, duty_shadow in; registered pwm_out bit out
module pwm_channel
  import pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic             load,
  input  logic [CNT_W-1:0] duty_shadow,
  output logic             pwm_out
);
  logic [CNT_W-1:0] duty_active;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_active <= '0;
      pwm_out     <= 1'b0;
    end else begin
      if (load) duty_active <= duty_shadow;
      pwm_out <= en && (cnt < duty_active);
    end
  end
endmodule

// File: rtl/iomem_pwm_leds.sv
// iomem_pwm_leds: iomem-mapped PWM LED driver; ports clk, reset, bus (iomem slave), pwm_out[NUM_CH], period_tick
module iomem_pwm_leds
  import pwm_pkg::*;
#(
  parameter int          NUM_CH  = 8,
  parameter logic [7:0]  BASE_HI = 8'h04
) (
  input  logic                clk,
  input  logic                reset,
  iomem_pwm_leds_if.slave     bus,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic                period_tick
);
  logic               en, en_nxt, sel, wr, ctrl_wr, tick, wrap, unused_addr;
  logic [1:0]         idx;
  logic [PRESC_W-1:0] presc, presc_nxt, pcnt;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        periods;
  logic [CNT_W-1:0]   duty_sh [8];
  logic [31:0]        rd_val;
  assign unused_addr = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};
  assign sel     = bus.iomem_valid && !bus.iomem_ready && bus.iomem_addr[31:24] == BASE_HI;
  assign idx     = bus.iomem_addr[3:2];
  assign wr      = sel && |bus.iomem_wstrb;
  assign ctrl_wr = wr && idx == REG_CTRL;
  assign tick    = en && pcnt >= presc;
  assign wrap    = tick && cnt == '1;
  assign en_nxt  = ctrl_wr && bus.iomem_wstrb[0] ? bus.iomem_wdata[EN_BIT] : en;
  assign presc_nxt = {ctrl_wr && bus.iomem_wstrb[3] ? bus.iomem_wdata[PRESC_LSB+8 +: 8] : presc[15:8],
                      ctrl_wr && bus.iomem_wstrb[2] ? bus.iomem_wdata[PRESC_LSB +: 8]   : presc[7:0]};
  always_comb begin
    rd_val = idx == REG_CTRL    ? (32'(presc) << PRESC_LSB) | (32'(en) << EN_BIT) :
             idx == REG_STATUS  ? {8'd0, cnt, periods} :
             idx == REG_DUTY_LO ? {duty_sh[3], duty_sh[2], duty_sh[1], duty_sh[0]} :
                                  {duty_sh[7], duty_sh[6], duty_sh[5], duty_sh[4]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      en              <= 1'b0;
      presc           <= '0;
      pcnt            <= '0;
      cnt             <= '0;
      periods         <= '0;
      period_tick     <= 1'b0;
      for (int k = 0; k < 8; k++) duty_sh[k] <= '0;
    end else begin
      bus.iomem_ready <= sel;
      bus.iomem_rdata <= sel ? rd_val : '0;
      en              <= en_nxt;
      presc           <= presc_nxt;
      pcnt            <= (!en || tick) ? '0 : pcnt + 1'b1;
      cnt             <= !en ? '0 : cnt + CNT_W'(tick);
      periods         <= periods + 16'(wrap);
      period_tick     <= wrap && en_nxt;
      for (int k = 0; k < 8; k++)
        if (wr && k < NUM_CH && bus.iomem_wstrb[k % 4] && idx == ((k < 4) ? REG_DUTY_LO : REG_DUTY_HI))
          duty_sh[k] <= bus.iomem_wdata[8*(k%4) +: 8];
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .cnt         (cnt),
      .load        (!en || wrap),
      .duty_shadow (duty_sh[g]),
      .pwm_out     (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_iomem_pwm_leds.sv
// tb_iomem_pwm_leds: scoreboarded bus reads plus per-period PWM duty windows for iomem_pwm_leds
module tb_iomem_pwm_leds;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pwm_out;
  logic period_tick;
  int n_cmp = 0, n_err = 0, n_ticks = 0, cyc = 0;
  int acc [8];
  int win [8];
  logic [31:0] exp_q [$];
  iomem_pwm_leds_if bus ();
  iomem_pwm_leds #(.NUM_CH(8), .BASE_HI(8'h04)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (period_tick) n_ticks <= n_ticks + 1;
    for (int k = 0; k < 8; k++) begin
      if (period_tick) win[k] <= acc[k];
      acc[k] <= (period_tick ? 0 : acc[k]) + int'(pwm_out[k]);
    end
  end
  task automatic xfer(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d, input string nm, output logic [31:0] r);
    bus.iomem_addr  = a;
    bus.iomem_wstrb = st;
    bus.iomem_wdata = d;
    bus.iomem_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.iomem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got %b expected 1", nm, bus.iomem_ready);
    end
    r = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(negedge clk);
    n_cmp++;
    if (bus.iomem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ready_drop: got %b expected 0", nm, bus.iomem_ready);
    end
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d, input string nm);
    logic [31:0] r;
    xfer(a, st, d, nm, r);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    logic [31:0] r, x;
    exp_q.push_back(e);
    xfer(a, 4'h0, 32'h0, nm, r);
    x = exp_q.pop_front();
    n_cmp++;
    if (r !== x) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, r, x);
    end
  endtask
  task automatic wait_ticks_to(input int t, input string nm);
    for (int i = 0; i < 3000 && n_ticks < t; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (n_ticks < t) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d ticks expected %0d", nm, n_ticks, t);
    end
  endtask
  task automatic check_int(input int got, input int want, input string nm);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask
  task automatic test_reset;
    n_cmp++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got pwm %h tick %b expected 00 0", pwm_out, period_tick);
    end
    for (int i = 0; i < 4; i++) rd(32'h0400_0000 + 32'(i * 4), 32'h0, "reset_rd");
  endtask
  task automatic test_duty;
    int t0, c;
    int exp_d [4] = '{64, 128, 255, 0};
    wr(32'h0400_0008, 4'hF, 32'h00FF_8040, "duty_lo");
    wr(32'h0400_0000, 4'hF, 32'h0000_0001, "ctrl_en");
    wait_ticks_to(n_ticks + 1, "first_wrap");
    t0 = cyc;
    rd(32'h0400_0004, 32'h0000_0001, "status_first_wrap");
    c = n_ticks;
    wait_ticks_to(c + 1, "second_wrap");
    check_int(cyc - t0, 256, "period_len_presc0");
    for (int k = 0; k < 4; k++) check_int(win[k], exp_d[k], $sformatf("duty_ch%0d", k));
  endtask
  task automatic test_presc;
    int t0;
    wr(32'h0400_0000, 4'hF, 32'h0003_0001, "ctrl_presc3");
    wait_ticks_to(n_ticks + 1, "presc3_sync");
    t0 = cyc;
    wait_ticks_to(n_ticks + 1, "presc3_wrap");
    check_int(cyc - t0, 1024, "period_len_presc3");
    t0 = cyc;
    @(negedge clk);
    wr(32'h0400_0000, 4'hF, 32'h0000_0001, "ctrl_presc0_pcnt2");
    wait_ticks_to(n_ticks + 1, "presc_drop_wrap");
    check_int(cyc - t0, 258, "presc_drop_period");
  endtask
  task automatic test_partial;
    int c;
    wait_ticks_to(n_ticks + 1, "partial_sync");
    c = n_ticks;
    repeat (100) @(negedge clk);
    wr(32'h0400_0008, 4'h1, 32'hAABB_CC10, "duty_byte0");
    rd(32'h0400_0008, 32'h00FF_8010, "duty_byte0_rb");
    wait_ticks_to(c + 1, "partial_wrap1");
    check_int(win[0], 64, "ch0_old_duty_held");
    check_int(win[1], 128, "ch1_unchanged");
    wait_ticks_to(c + 2, "partial_wrap2");
    check_int(win[0], 16, "ch0_new_duty");
    c = n_ticks;
    repeat (255) @(negedge clk);
    wr(32'h0400_0008, 4'h1, 32'h0000_0020, "duty_on_wrap");
    wait_ticks_to(c + 2, "onwrap_wrap2");
    check_int(win[0], 16, "ch0_wrap_edge_old");
    wait_ticks_to(c + 3, "onwrap_wrap3");
    check_int(win[0], 32, "ch0_wrap_edge_new");
  endtask
  task automatic test_disable;
    int c;
    int exp_d [8] = '{32, 128, 255, 0, 255, 255, 255, 255};
    wr(32'h0400_000C, 4'hF, 32'hFFFF_FFFF, "duty_hi");
    wait_ticks_to(n_ticks + 1, "disable_sync");
    repeat (50) @(negedge clk);
    check_int(int'(pwm_out[2]), 1, "ch2_high_before_disable");
    wr(32'h0400_0000, 4'hF, 32'h0, "ctrl_disable");
    n_cmp++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL disable_outputs: got pwm %h tick %b expected 00 0", pwm_out, period_tick);
    end
    rd(32'h0400_0004, {16'h0, 16'(n_ticks)}, "status_disabled");
    repeat (300) @(negedge clk);
    rd(32'h0400_0004, {16'h0, 16'(n_ticks)}, "status_held");
    wr(32'h0400_0000, 4'hF, 32'h1, "ctrl_reenable");
    rd(32'h0400_0004, {8'h0, 8'h01, 16'(n_ticks)}, "status_restart");
    c = n_ticks;
    wait_ticks_to(c + 2, "reenable_wraps");
    for (int k = 0; k < 8; k++) check_int(win[k], exp_d[k], $sformatf("reenable_ch%0d", k));
  endtask
  task automatic test_wrap_disable;
    int c;
    wait_ticks_to(n_ticks + 1, "wrapdis_sync");
    c = n_ticks;
    repeat (255) @(negedge clk);
    wr(32'h0400_0000, 4'hF, 32'h0, "ctrl_disable_on_wrap");
    repeat (10) @(negedge clk);
    #1;
    check_int(n_ticks, c, "no_tick_on_disable_wrap");
    rd(32'h0400_0004, {16'h0, 16'(c + 1)}, "periods_counted_on_disable_wrap");
  endtask
  task automatic test_unselected;
    bit seen = 0;
    bus.iomem_addr  = 32'h0300_0008;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'h1234_5678;
    bus.iomem_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.iomem_ready !== 1'b0) seen = 1;
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL unselected_ready: got 1 expected 0");
    end
    @(negedge clk);
    #1;
    rd(32'h0400_0008, 32'h00FF_8020, "unselected_no_write");
    rd(32'h04FF_FFF9, 32'h00FF_8020, "alias_duty_lo");
    wr(32'h0400_0004, 4'hF, 32'hFFFF_FFFF, "status_write");
    rd(32'h0400_0004, {16'h0, 16'(n_ticks + 1)}, "status_ro");
    wr(32'h0400_0000, 4'hF, 32'h0000_FFFE, "ctrl_reserved");
    rd(32'h0400_0000, 32'h0, "ctrl_reserved_rb");
    wr(32'h0400_0000, 4'hF, 32'h1234_0000, "ctrl_presc_big");
    wr(32'h0400_0000, 4'h1, 32'hFFFF_FF01, "ctrl_lane0_en");
    rd(32'h0400_0000, 32'h1234_0001, "ctrl_lanes_rb");
    n_cmp++;
    if (pwm_out !== 8'hF7) begin
      n_err++;
      $display("FAIL pwm_at_cnt0: got %h expected f7", pwm_out);
    end
  endtask
  task automatic test_reset_mid;
    bus.iomem_addr  = 32'h0400_0008;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'hFFFF_FFFF;
    bus.iomem_valid = 1'b1;
    @(posedge clk);
    #1;
    check_int(int'(bus.iomem_ready), 1, "mid_ready_before_reset");
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0 || pwm_out !== 8'h00 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got ready %b rdata %h pwm %h tick %b expected 0 0 00 0",
               bus.iomem_ready, bus.iomem_rdata, pwm_out, period_tick);
    end
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) rd(32'h0400_0000 + 32'(i * 4), 32'h0, "post_reset_rd");
  endtask
  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset;
    test_duty;
    test_presc;
    test_partial;
    test_disable;
    test_wrap_disable;
    test_unselected;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
